// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: queues CPU samples, issues them one at a time to the FIR core and holds each result for readback
module fir_seq_ctrl #(
  parameter int DW      = 8,
  parameter int YW      = 19,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       enable,
  input  logic                       clr,
  input  logic                       smp_wr,
  input  logic [DW-1:0]              smp_data,
  input  logic                       res_rd,
  output logic [YW-1:0]              res_data,
  output logic                       res_valid,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       busy,
  output logic                       ovf,
  output logic                       tmo,
  output logic [DW-1:0]              fir_x,
  output logic                       fir_valid_in,
  input  logic [YW-1:0]              fir_y,
  input  logic                       fir_valid_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  logic [1:0]    state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic          full, pop, push;
  assign full         = fifo_level == LW'(DEPTH);
  assign pop          = state == ISSUE && !clr;
  assign push         = smp_wr && !clr && (!full || pop);
  assign busy         = state != IDLE;
  assign fir_valid_in = state == ISSUE;
  assign fir_x        = state == ISSUE ? mem[rd_ptr] : '0;
  // sample storage; contents only matter once a pointer covers them
  always_ff @(posedge ACLK)
    if (push) mem[wr_ptr] <= smp_data;
  // FIFO pointers and occupancy; clr flushes everything
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  // issue/wait sequencer with result holding, sticky flags and core watchdog
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      ovf       <= 1'b0;
      tmo       <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      ovf       <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      if (smp_wr && !push) ovf <= 1'b1;
      if (res_rd) res_valid <= 1'b0;
      case (state)
        IDLE:  if (enable && fifo_level != '0 && !res_valid) state <= ISSUE;
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT:
          if (fir_valid_out) begin
            res_data  <= fir_y;
            res_valid <= 1'b1;
            state     <= IDLE;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            tmo   <= 1'b1;
            state <= IDLE;
          end else tmo_cnt <= tmo_cnt + TW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: directed and randomized checks of the sample sequencer against a queue-based reference
module tb_fir_seq_ctrl;
  localparam int DW = 8, YW = 19, DEPTH = 4, TIMEOUT = 32;
  logic ACLK = 0, ARESETN = 0, enable = 0, clr = 0, smp_wr = 0, res_rd = 0, fir_valid_out = 0;
  logic [DW-1:0] smp_data = '0;
  logic [YW-1:0] fir_y = '0;
  logic [YW-1:0] res_data;
  logic          res_valid, busy, ovf, tmo, fir_valid_in;
  logic [2:0]    fifo_level;
  logic [DW-1:0] fir_x;
  int errors = 0, checks = 0;

  fir_seq_ctrl #(.DW(DW), .YW(YW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .clr(clr), .smp_wr(smp_wr),
    .smp_data(smp_data), .res_rd(res_rd), .res_data(res_data), .res_valid(res_valid),
    .fifo_level(fifo_level), .busy(busy), .ovf(ovf), .tmo(tmo), .fir_x(fir_x),
    .fir_valid_in(fir_valid_in), .fir_y(fir_y), .fir_valid_out(fir_valid_out));

  always #5 ACLK = ~ACLK;

  task automatic cyc();
    @(negedge ACLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    smp_wr = 1; smp_data = d;
    cyc();
    smp_wr = 0;
  endtask

  task automatic wait_issue(input int budget);
    int n = 0;
    while (fir_valid_in !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    chk("issue_seen", fir_valid_in, 1);
  endtask

  // called in the ISSUE cycle; core answers in the lat-th WAIT cycle
  task automatic serve(input logic [YW-1:0] y, input int lat);
    cyc();
    chk("strobe_one_cycle", fir_valid_in, 0);
    chk("busy_in_wait", busy, 1);
    repeat (lat - 1) cyc();
    fir_valid_out = 1; fir_y = y;
    cyc();
    fir_valid_out = 0;
    chk("res_valid_set", res_valid, 1);
    chk("res_data", res_data, y);
    chk("idle_after_result", busy, 0);
  endtask

  task automatic read();
    res_rd = 1;
    cyc();
    res_rd = 0;
    chk("res_valid_cleared", res_valid, 0);
  endtask

  task automatic pulse_clr();
    clr = 1;
    cyc();
    clr = 0;
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] d;
    logic [YW-1:0] y;
    bit exp_ovf;
    int n, seen;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_fir_valid_in", fir_valid_in, 0);
    cyc();
    ARESETN = 1;
    cyc();
    // basic transaction and issue latency
    enable = 1;
    push(8'h05);
    chk("basic_no_early_issue", fir_valid_in, 0);
    chk("basic_level", fifo_level, 1);
    cyc();
    chk("basic_issue_t2", fir_valid_in, 1);
    chk("basic_fir_x", fir_x, 8'h05);
    serve(19'h00123, 3);
    read();
    // asynchronous reset in the middle of WAIT
    enable = 0;
    push(8'hA1);
    push(8'hA2);
    enable = 1;
    wait_issue(5);
    cyc();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_level", fifo_level, 1);
    #2 ARESETN = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_res_data", res_data, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_fir_x", fir_x, 0);
    chk("arst_fir_valid_in", fir_valid_in, 0);
    cyc();
    ARESETN = 1;
    repeat (3) cyc();
    chk("post_rst_idle", busy, 0);
    chk("post_rst_no_issue", fir_valid_in, 0);
    // ordering and overflow
    enable = 0;
    for (int k = 1; k <= 5; k++) push(DW'(k));
    chk("full_level", fifo_level, 4);
    chk("full_ovf", ovf, 1);
    enable = 1;
    for (int k = 1; k <= 4; k++) begin
      wait_issue(5);
      chk("order_fir_x", fir_x, k);
      serve(YW'(k * 1000), 2);
      read();
    end
    chk("drain_level", fifo_level, 0);
    chk("ovf_sticky", ovf, 1);
    pulse_clr();
    chk("clr_ovf", ovf, 0);
    // timeout
    enable = 0;
    push(8'h3C);
    push(8'h4D);
    enable = 1;
    wait_issue(5);
    chk("tmo_first_x", fir_x, 8'h3C);
    cyc();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    chk("tmo_wait_cycles", n, TIMEOUT);
    chk("tmo_flag", tmo, 1);
    chk("tmo_no_result", res_valid, 0);
    wait_issue(5);
    chk("tmo_next_x", fir_x, 8'h4D);
    serve(19'h7ABCD, 4);
    read();
    chk("tmo_sticky", tmo, 1);
    pulse_clr();
    chk("clr_tmo", tmo, 0);
    // hold-off while a result is unread
    enable = 0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    enable = 1;
    wait_issue(5);
    serve(19'h00042, 1);
    seen = 0;
    repeat (6) begin
      cyc();
      if (fir_valid_in === 1'b1) seen++;
    end
    chk("holdoff_no_issue", seen, 0);
    chk("holdoff_level", fifo_level, 2);
    read();
    chk("holdoff_gap", fir_valid_in, 0);
    cyc();
    chk("holdoff_issue_2", fir_valid_in, 1);
    chk("holdoff_x", fir_x, 8'h22);
    serve(19'h00043, 2);
    read();
    wait_issue(5);
    chk("holdoff_x3", fir_x, 8'h33);
    serve(19'h00044, 2);
    read();
    // clr during WAIT, and clr with a simultaneous write on a full FIFO
    enable = 0;
    for (int k = 0; k < 5; k++) push(8'h90 + DW'(k));
    enable = 1;
    wait_issue(5);
    cyc();
    chk("pre_clr_level", fifo_level, 3);
    chk("pre_clr_ovf", ovf, 1);
    pulse_clr();
    chk("clr_level", fifo_level, 0);
    chk("clr_ovf_wait", ovf, 0);
    chk("clr_busy", busy, 0);
    chk("clr_res_valid", res_valid, 0);
    enable = 0;
    fir_valid_out = 1; fir_y = 19'h55555;
    cyc();
    fir_valid_out = 0;
    chk("late_valid_ignored", res_valid, 0);
    chk("late_data_ignored", res_data, 0);
    for (int k = 0; k < 4; k++) push(DW'(k));
    smp_wr = 1; clr = 1; smp_data = 8'hEE;
    cyc();
    smp_wr = 0; clr = 0;
    chk("clr_wr_level", fifo_level, 0);
    chk("clr_wr_no_ovf", ovf, 0);
    // randomized rounds against a queue model
    for (int r = 0; r < 12; r++) begin
      enable = 0;
      exp_ovf = 0;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        d = DW'($urandom);
        push(d);
        if (q.size() < DEPTH) q.push_back(d);
        else exp_ovf = 1;
      end
      chk("rnd_level", fifo_level, q.size());
      chk("rnd_ovf", ovf, exp_ovf);
      enable = 1;
      while (q.size() > 0) begin
        wait_issue(5);
        chk("rnd_fir_x", fir_x, q.pop_front());
        y = YW'($urandom);
        serve(y, $urandom_range(1, 8));
        read();
      end
      pulse_clr();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
